// File: rtl/call_dispatcher_if.sv
// Bundles the dispatcher's call, car and report signals.
// master = call/car side that drives inputs, slave = dispatcher.
interface call_dispatcher_if #(
    parameter int NFLOORS = 6,
    parameter int CARW    = 4
);
    localparam int FW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;

    logic                en;
    logic [NFLOORS-1:0]  call_btn;
    logic [CARW-1:0]     car0_pos;
    logic [CARW-1:0]     car1_pos;
    logic                car0_stop;
    logic                car1_stop;
    logic [NFLOORS-1:0]  car0_req;
    logic [NFLOORS-1:0]  car1_req;
    logic [NFLOORS-1:0]  pending;
    logic                asg_valid;
    logic                asg_car;
    logic [FW-1:0]       asg_floor;
    logic                busy;

    modport master (
        output en, call_btn, car0_pos, car1_pos, car0_stop, car1_stop,
        input  car0_req, car1_req, pending, asg_valid, asg_car, asg_floor, busy
    );

    modport slave (
        input  en, call_btn, car0_pos, car1_pos, car0_stop, car1_stop,
        output car0_req, car1_req, pending, asg_valid, asg_car, asg_floor, busy
    );
endinterface

// File: rtl/call_dispatcher.sv
// Two-car hall-call dispatcher: synchronizes call buttons, latches calls,
// assigns each unassigned call to the nearer car (round-robin on ties)
// and clears calls when a car stops at that floor.
module call_dispatcher #(
    parameter int NFLOORS = 6,
    parameter int CARW    = 4
) (
    input  logic clk,
    input  logic rst,
    call_dispatcher_if.slave bus
);
    localparam int FW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;
    // Highest legal position: top floor, whole-floor aligned.
    localparam logic [CARW-1:0] MAXPOS_V = CARW'(2 * (NFLOORS - 1));

    typedef enum logic {IDLE, ASSIGN} state_t;

    state_t             r_state, w_state_next;
    logic [NFLOORS-1:0] r_sync1, r_sync2, r_sync3;
    logic [NFLOORS-1:0] r_pending, r_req0, r_req1;
    logic [FW-1:0]      r_target;
    logic               r_rr;
    logic               r_asg_valid, r_asg_car;
    logic [FW-1:0]      r_asg_floor;

    logic [NFLOORS-1:0] w_rise, w_clear, w_unassigned, w_asg_mask;
    logic [FW-1:0]      w_first;
    logic [CARW-1:0]    w_tpos, w_dist0, w_dist1;
    logic               w_elig0, w_elig1;
    logic               w_load_target, w_do_asg, w_asg_car, w_tie;

    // A stop counts only at a whole, in-range floor; both cars may clear at once.
    generate
        for (genvar gi = 0; gi < NFLOORS; gi++) begin : g_clear
            assign w_clear[gi] =
                (bus.car0_stop && !bus.car0_pos[0] && (bus.car0_pos <= MAXPOS_V) &&
                 (bus.car0_pos[CARW-1:1] == (CARW-1)'(gi))) ||
                (bus.car1_stop && !bus.car1_pos[0] && (bus.car1_pos <= MAXPOS_V) &&
                 (bus.car1_pos[CARW-1:1] == (CARW-1)'(gi)));
        end
    endgenerate

    assign w_rise       = r_sync2 & ~r_sync3;
    assign w_unassigned = r_pending & ~r_req0 & ~r_req1;

    assign w_tpos  = CARW'({r_target, 1'b0});
    assign w_dist0 = (w_tpos >= bus.car0_pos) ? (w_tpos - bus.car0_pos) : (bus.car0_pos - w_tpos);
    assign w_dist1 = (w_tpos >= bus.car1_pos) ? (w_tpos - bus.car1_pos) : (bus.car1_pos - w_tpos);
    assign w_elig0 = (bus.car0_pos <= MAXPOS_V);
    assign w_elig1 = (bus.car1_pos <= MAXPOS_V);

    // Lowest-index unassigned floor becomes the next target.
    always_comb begin
        w_first = '0;
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (w_unassigned[i]) w_first = FW'(i);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state and assignment decision; a target cleared meanwhile aborts.
    always_comb begin
        w_state_next  = r_state;
        w_load_target = 1'b0;
        w_do_asg      = 1'b0;
        w_asg_car     = 1'b0;
        w_tie         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en && (|w_unassigned)) begin
                    w_state_next  = ASSIGN;
                    w_load_target = 1'b1;
                end
            end
            ASSIGN: begin
                w_state_next = IDLE;
                if (r_pending[r_target] && !w_clear[r_target] && (w_elig0 || w_elig1)) begin
                    w_do_asg = 1'b1;
                    if (w_elig0 && w_elig1) begin
                        if (w_dist0 < w_dist1)      w_asg_car = 1'b0;
                        else if (w_dist1 < w_dist0) w_asg_car = 1'b1;
                        else begin
                            w_tie     = 1'b1;
                            w_asg_car = r_rr;
                        end
                    end else begin
                        w_asg_car = !w_elig0;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_asg_mask = w_do_asg ? (NFLOORS'(1) << r_target) : '0;

    // Button synchronizer plus the delayed copy used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= bus.call_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Call latching and per-car requests; clearing wins over set and assignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_req0    <= '0;
            r_req1    <= '0;
        end else begin
            r_pending <= (r_pending | w_rise) & ~w_clear;
            r_req0    <= (r_req0 | (w_asg_car ? '0 : w_asg_mask)) & ~w_clear;
            r_req1    <= (r_req1 | (w_asg_car ? w_asg_mask : '0)) & ~w_clear;
        end
    end

    // Target capture, tie-break pointer and the one-cycle assignment report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target    <= '0;
            r_rr        <= 1'b0;
            r_asg_valid <= 1'b0;
            r_asg_car   <= 1'b0;
            r_asg_floor <= '0;
        end else begin
            r_asg_valid <= w_do_asg;
            if (w_load_target) r_target <= w_first;
            if (w_do_asg) begin
                r_asg_car   <= w_asg_car;
                r_asg_floor <= r_target;
                if (w_tie) r_rr <= ~r_rr;
            end
        end
    end

    assign bus.pending   = r_pending;
    assign bus.car0_req  = r_req0;
    assign bus.car1_req  = r_req1;
    assign bus.asg_valid = r_asg_valid;
    assign bus.asg_car   = r_asg_car;
    assign bus.asg_floor = r_asg_floor;
    assign bus.busy      = (r_state == ASSIGN);
endmodule

// File: tb/tb_call_dispatcher.sv
// Self-checking bench for call_dispatcher: directed scenarios followed by
// randomized traffic, all compared each cycle against a call-level model.
module tb_call_dispatcher;
    localparam int NF = 6;
    localparam int CW = 4;
    localparam int MAXP = 2 * (NF - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    call_dispatcher_if #(.NFLOORS(NF), .CARW(CW)) bus();
    call_dispatcher #(.NFLOORS(NF), .CARW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: recent button samples, latched calls, per-car requests,
    // the call currently being decided (-1 = none) and the last report.
    logic [NF-1:0] m_hist [3];
    logic [NF-1:0] m_pend;
    logic [NF-1:0] m_req [2];
    int            m_tgt;
    bit            m_rr, m_av, m_ac;
    int            m_af;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_pend = '0; m_req[0] = '0; m_req[1] = '0;
        m_tgt = -1; m_rr = 0; m_av = 0; m_ac = 0; m_af = 0;
    endtask

    // One clock edge of the dispatcher's behaviour, from the rules directly.
    task automatic model_step();
        logic [NF-1:0] rise, clr, unas;
        int p0, p1, d0, d1, car;
        bit e0, e1;
        if (rst) begin
            model_reset();
            return;
        end
        p0 = int'(bus.car0_pos);
        p1 = int'(bus.car1_pos);
        clr = '0;
        if (bus.car0_stop && (p0 % 2 == 0) && p0 <= MAXP) clr[p0 / 2] = 1'b1;
        if (bus.car1_stop && (p1 % 2 == 0) && p1 <= MAXP) clr[p1 / 2] = 1'b1;
        rise = m_hist[1] & ~m_hist[2];
        unas = m_pend & ~m_req[0] & ~m_req[1];
        m_av = 0;
        if (m_tgt >= 0) begin
            e0 = (p0 <= MAXP);
            e1 = (p1 <= MAXP);
            d0 = (2 * m_tgt > p0) ? 2 * m_tgt - p0 : p0 - 2 * m_tgt;
            d1 = (2 * m_tgt > p1) ? 2 * m_tgt - p1 : p1 - 2 * m_tgt;
            if (m_pend[m_tgt] && !clr[m_tgt] && (e0 || e1)) begin
                if (e0 && e1) begin
                    if (d0 < d1)      car = 0;
                    else if (d1 < d0) car = 1;
                    else begin
                        car  = int'(m_rr);
                        m_rr = !m_rr;
                    end
                end else begin
                    car = e0 ? 0 : 1;
                end
                m_req[car][m_tgt] = 1'b1;
                m_av = 1;
                m_ac = (car == 1);
                m_af = m_tgt;
            end
            m_tgt = -1;
        end else if (bus.en && unas != 0) begin
            for (int i = NF - 1; i >= 0; i--) if (unas[i]) m_tgt = i;
        end
        m_pend   = (m_pend | rise) & ~clr;
        m_req[0] = m_req[0] & ~clr;
        m_req[1] = m_req[1] & ~clr;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = bus.call_btn;
    endtask

    task automatic compare_all();
        check_val("pending",   bus.pending,   m_pend);
        check_val("car0_req",  bus.car0_req,  m_req[0]);
        check_val("car1_req",  bus.car1_req,  m_req[1]);
        check_val("asg_valid", bus.asg_valid, m_av);
        check_val("asg_car",   bus.asg_car,   m_ac);
        check_val("asg_floor", bus.asg_floor, m_af);
        check_val("busy",      bus.busy,      (m_tgt >= 0));
        if (bus.asg_valid)
            $display("[TB] cycle %0d assign floor %0d -> car %0d", cyc, bus.asg_floor, bus.asg_car);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        bus.en = 1'b1; bus.call_btn = '0;
        bus.car0_pos = '0; bus.car1_pos = '0;
        bus.car0_stop = 1'b0; bus.car1_stop = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_pending", bus.pending, 0);
        check_val("rst_req0",    bus.car0_req, 0);
        check_val("rst_req1",    bus.car1_req, 0);
        check_val("rst_asg",     {bus.asg_valid, bus.asg_car, bus.asg_floor}, 0);
        check_val("rst_busy",    bus.busy, 0);
        rst = 1'b0;

        // Single call, car0 much nearer.
        bus.car0_pos = 4'd0; bus.car1_pos = 4'd10; bus.call_btn = 6'b000010;
        repeat (3) cycle();
        check_val("r031_pend", bus.pending, 6'b000010);
        repeat (2) cycle();
        check_val("r031_valid", bus.asg_valid, 1);
        check_val("r031_req0",  bus.car0_req, 6'b000010);
        check_val("r031_car",   bus.asg_car, 0);
        check_val("r031_floor", bus.asg_floor, 1);
        bus.call_btn = '0; bus.car0_pos = 4'd2; bus.car0_stop = 1'b1;
        cycle();
        bus.car0_stop = 1'b0;
        check_val("r031_clr", {bus.pending, bus.car0_req}, 0);

        // Two simultaneous calls with equidistant cars: round-robin ties.
        bus.car0_pos = 4'd4; bus.car1_pos = 4'd4; bus.call_btn = 6'b100001;
        repeat (5) cycle();
        check_val("r032_a", {bus.asg_valid, bus.asg_car, bus.asg_floor}, {1'b1, 1'b0, 3'd0});
        repeat (2) cycle();
        check_val("r032_b", {bus.asg_valid, bus.asg_car, bus.asg_floor}, {1'b1, 1'b1, 3'd5});
        bus.call_btn = '0;
        bus.car0_pos = 4'd0; bus.car1_pos = 4'd10;
        bus.car0_stop = 1'b1; bus.car1_stop = 1'b1;
        cycle();
        bus.car0_stop = 1'b0; bus.car1_stop = 1'b0;
        check_val("r032_clr", bus.pending, 0);

        // Both cars out of range: call stays pending, then reset mid-ASSIGN.
        bus.car0_pos = 4'd15; bus.car1_pos = 4'd15; bus.call_btn = 6'b010000;
        repeat (8) cycle();
        bus.call_btn = '0;
        check_val("r036_hold", bus.pending, 6'b010000);
        begin : wait_busy
            for (int i = 0; i < 10; i++) begin
                if (bus.busy) disable wait_busy;
                cycle();
            end
        end
        check_val("r036_busy_seen", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_val("r036_rst_out", {bus.pending, bus.car0_req, bus.car1_req,
                                   bus.asg_valid, bus.asg_car, bus.asg_floor, bus.busy}, 0);
        cycle();
        rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < NF; b++)
                if ($urandom_range(0, 7) == 0) bus.call_btn[b] = ~bus.call_btn[b];
            if ($urandom_range(0, 3) == 0) bus.car0_pos = CW'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) bus.car1_pos = CW'($urandom_range(0, 12));
            bus.car0_stop = ($urandom_range(0, 4) == 0);
            bus.car1_stop = ($urandom_range(0, 4) == 0);
            bus.en        = ($urandom_range(0, 9) != 0);
            rst           = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/call_dispatcher.md
CALL_DISPATCHER -- requirements
Module: call_dispatcher

Interface
REQ-001 SHALL have parameters: NFLOORS, default 6, number of served floors; CARW, default 4, width of car position (half-floor units).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  scheduler advance enable.
REQ-005 SHALL have port call_btn  input  6  raw hall call buttons, bit i = floor i, asynchronous to clk.
REQ-006 SHALL have ports car0_pos, car1_pos  input  4  car position: bits[3:1] whole floor, bit[0]=1 means between floors; valid range 0..10.
REQ-007 SHALL have ports car0_stop, car1_stop  input  1  one-cycle pulse, car stopped at a whole floor.
REQ-008 SHALL have ports car0_req, car1_req  output  6  calls assigned to each car, fed to that car's floors_triggered.
REQ-009 SHALL have port pending  output  6  latched calls not yet served.
REQ-010 SHALL have ports asg_valid  output  1, asg_car  output  1, asg_floor  output  3  one-cycle assignment report.
REQ-011 SHALL have port busy  output  1  high while the FSM is in ASSIGN.

Function
REQ-012 SHALL pass each call_btn bit through a 2-flop synchronizer, then detect rising edges against a third registered copy.
REQ-013 SHALL set pending[i] on the clock edge after a detected rising edge on bit i, so pending rises 3 edges after call_btn is first sampled high.
REQ-014 SHALL ignore an edge on a floor whose pending bit is already set (no duplicate assignment).
REQ-015 SHALL define unassigned = pending & ~car0_req & ~car1_req.
REQ-016 SHALL implement FSM states IDLE and ASSIGN: IDLE->ASSIGN when en=1 and unassigned!=0; ASSIGN->IDLE always after one cycle.
REQ-017 SHALL select in IDLE the lowest-index unassigned floor f and register it as the target.
REQ-018 SHALL compute in ASSIGN dist_k = |{f,1'b0} - carK_pos| as 4-bit unsigned; a car with pos>10 SHALL be ineligible.
REQ-019 SHALL assign the target to the car with smaller dist; on a tie, to the car indexed by the round-robin pointer rr, then toggle rr.
REQ-020 SHALL, on assignment, set carK_req[f] and pulse asg_valid=1, asg_car=K, asg_floor=f in the same cycle; rr SHALL change only on ties.
REQ-021 SHALL, when both cars are ineligible, make no assignment, keep asg_valid=0, and return to IDLE; the call stays pending.
REQ-022 SHALL, on carK_stop=1 with carK_pos[0]=0, clear pending[p] and car0_req[p]/car1_req[p], p=carK_pos[3:1], on that edge.
REQ-023 SHALL ignore carK_stop when carK_pos[0]=1 or pos>10.
REQ-024 SHALL give clear priority over set and over assignment for the same floor in the same cycle; the colliding button edge is dropped.
REQ-025 SHALL abort an in-flight ASSIGN whose target is cleared that cycle (asg_valid=0), then return to IDLE.
REQ-026 SHALL, when en=0, hold the FSM in IDLE (an ASSIGN in progress completes); latching and clearing continue.
REQ-027 SHALL let both cars clear the same or different floors in one cycle.
REQ-028 SHALL throughput at most one assignment per 2 cycles.

Reset
REQ-029 SHALL drive on rst: synchronizers, pending, car0_req, car1_req = 0; FSM = IDLE; rr = 0; asg_valid = 0; asg_car = 0; asg_floor = 0; busy = 0.
REQ-030 SHALL discard all calls on a mid-operation rst and resume in IDLE with no report pulse.

Verification
REQ-031 SHALL cover: car0_pos=0, car1_pos=10, press floor 1 -> pending=000010 at 3rd edge, car0_req=000010, asg_car=0, asg_floor=1 two edges later.
REQ-032 SHALL cover: both pos=4, press floors 0 and 5 together -> floor 0 goes to car0 (rr 0->1), then floor 5 goes to car1 (rr 1->0), 2 cycles apart.
REQ-033 SHALL cover: car1_req=001000, car1_pos=6, car1_stop pulse -> car1_req=0 and pending[3]=0 next edge; same with pos=7 -> no change.
REQ-034 SHALL cover: car0_stop at pos=4 in the same cycle as a floor-2 edge -> pending[2]=0, no assignment.
REQ-035 SHALL cover: en=0 with 3 calls latched -> pending=3 bits, no asg_valid; en=1 -> 3 asg_valid pulses, 2 cycles apart.
REQ-036 SHALL cover: both pos=15 with a call latched -> no assignment, pending held; rst mid-ASSIGN -> all outputs 0.
